int_res_station: RTL and testbench

//  Integer reservation station directly upstream of the issue arbiter. Holds dispatched ALU/branch ops

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/int_rs_entry.sv | 22 ++
 rtl/int_res_station.sv | 90 +++++++++
 tb/tb_int_res_station.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU op encodings and reservation-station entry types
package riscv_pkg;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 5;
  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd9;
  localparam logic [OP_W-1:0] BR_EQ    = 5'd16;
  localparam logic [OP_W-1:0] BR_NE    = 5'd17;
  localparam logic [OP_W-1:0] BR_LT    = 5'd18;
  localparam logic [OP_W-1:0] BR_GE    = 5'd19;
  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } rs_opnd_t;
  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] rd_tag;
    rs_opnd_t         rs1;
    rs_opnd_t         rs2;
  } rs_entry_t;
  // A pending operand whose producer tag is on the CDB takes the broadcast value.
  function automatic rs_opnd_t cdb_snoop(rs_opnd_t o, logic cv, logic [TAG_W-1:0] ct, logic [XLEN-1:0] cd);
    return (!o.rdy && cv && o.tag == ct) ? rs_opnd_t'{1'b1, o.tag, cd} : o;
  endfunction
endpackage

// File: rtl/int_rs_entry.sv
// int_rs_entry: one reservation-station slot; w is the slot contents with the current CDB applied
module int_rs_entry
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  rs_entry_t        d,
  output rs_entry_t        q,
  output rs_entry_t        w
);
  always_comb begin
    w = q;
    w.rs1 = cdb_snoop(q.rs1, cdb_valid, cdb_tag, cdb_data);
    w.rs2 = cdb_snoop(q.rs2, cdb_valid, cdb_tag, cdb_data);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/int_res_station.sv
// int_res_station: collapsing age-ordered integer reservation station with CDB snoop.
// Define CDB_WAKEUP_BYPASS_EN to let the current CDB broadcast wake and feed an entry in the same cycle.
module int_res_station
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_rd_tag,
  input  logic             disp_rs1_rdy,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [XLEN-1:0]  disp_rs1_val,
  input  logic             disp_rs2_rdy,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic [XLEN-1:0]  disp_rs2_val,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             ready_int,
  input  logic             issue_int,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_rd_tag,
  output logic [XLEN-1:0]  iss_rs1_val,
  output logic [XLEN-1:0]  iss_rs2_val
);
  localparam int IW = $clog2(DEPTH);
  rs_entry_t q [DEPTH];
  rs_entry_t w [DEPTH];
  rs_entry_t c [DEPTH];
  rs_entry_t d [DEPTH];
  rs_entry_t nd;
  logic [DEPTH-1:0] vld, rdy;
  logic [IW-1:0] sel;
  logic [IW:0] cnt, wslot;
  logic pop, acc;
  assign nd = '{valid: 1'b1, op: disp_op, rd_tag: disp_rd_tag,
                rs1: cdb_snoop(rs_opnd_t'{disp_rs1_rdy, disp_rs1_tag, disp_rs1_val}, cdb_valid, cdb_tag, cdb_data),
                rs2: cdb_snoop(rs_opnd_t'{disp_rs2_rdy, disp_rs2_tag, disp_rs2_val}, cdb_valid, cdb_tag, cdb_data)};
  assign rs_full = &vld;
  assign ready_int = |rdy;
  assign pop = issue_int & ready_int;
  assign acc = disp_valid & ~rs_full;
  // Valid entries are always packed from slot 0, so the free slot after a pop is cnt - pop.
  assign wslot = cnt - (IW+1)'(pop);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + (IW+1)'(vld[i]);
  end
  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) sel = rdy[i] ? IW'(i) : sel;
  end
  assign iss_op      = ready_int ? c[sel].op      : '0;
  assign iss_rd_tag  = ready_int ? c[sel].rd_tag  : '0;
  assign iss_rs1_val = ready_int ? c[sel].rs1.val : '0;
  assign iss_rs2_val = ready_int ? c[sel].rs2.val : '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_entry_t up;
    if (i < DEPTH - 1) begin : g_mid
      assign up = w[i+1];
    end else begin : g_last
      assign up = '0;
    end
    assign vld[i] = q[i].valid;
`ifdef CDB_WAKEUP_BYPASS_EN
    assign c[i] = w[i];
`else
    assign c[i] = q[i];
`endif
    assign rdy[i] = c[i].valid & c[i].rs1.rdy & c[i].rs2.rdy;
    assign d[i] = flush ? '0 :
                  (acc && wslot == (IW+1)'(i)) ? nd :
                  (pop && (IW+1)'(i) >= {1'b0, sel}) ? up : w[i];
    int_rs_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .d         (d[i]),
      .q         (q[i]),
      .w         (w[i])
    );
  end
endmodule

// File: tb/tb_int_res_station.sv
// tb_int_res_station: vector table with issue scoreboard for int_res_station (either CDB_WAKEUP_BYPASS_EN build)
module tb_int_res_station;
  import riscv_pkg::*;
`ifdef CDB_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, reset = 0, flush = 0, disp_valid = 0, disp_rs1_rdy = 0, disp_rs2_rdy = 0;
  logic cdb_valid = 0, issue_int = 0;
  logic [OP_W-1:0] disp_op = 0;
  logic [TAG_W-1:0] disp_rd_tag = 0, disp_rs1_tag = 0, disp_rs2_tag = 0, cdb_tag = 0;
  logic [XLEN-1:0] disp_rs1_val = 0, disp_rs2_val = 0, cdb_data = 0;
  logic rs_full, ready_int;
  logic [OP_W-1:0] iss_op;
  logic [TAG_W-1:0] iss_rd_tag;
  logic [XLEN-1:0] iss_rs1_val, iss_rs2_val;

  always #5 clk = ~clk;

  int_res_station dut (
    .clk(clk), .reset(reset), .flush(flush), .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_rd_tag(disp_rd_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs2_val(disp_rs2_val), .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .ready_int(ready_int), .issue_int(issue_int), .iss_op(iss_op),
    .iss_rd_tag(iss_rd_tag), .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val)
  );

  typedef struct {
    logic fl, dv;
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] rd;
    logic r1;
    logic [TAG_W-1:0] t1;
    logic [XLEN-1:0] v1;
    logic r2;
    logic [TAG_W-1:0] t2;
    logic [XLEN-1:0] v2;
    logic cv;
    logic [TAG_W-1:0] ct;
    logic [XLEN-1:0] cd;
    logic iss, ef, er;
    logic [OP_W-1:0] eop;
    logic [TAG_W-1:0] erd;
    logic [XLEN-1:0] e1, e2;
  } vec_t;
  typedef struct {
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] rd;
    logic [XLEN-1:0] v1, v2;
  } pay_t;

  vec_t tbl[$];
  pay_t exp_q[$];
  int checks = 0, failures = 0;

  function automatic vec_t mk(logic fl, logic dv, logic [OP_W-1:0] op, logic [TAG_W-1:0] rd,
                              logic r1, logic [TAG_W-1:0] t1, logic [XLEN-1:0] v1,
                              logic r2, logic [TAG_W-1:0] t2, logic [XLEN-1:0] v2,
                              logic cv, logic [TAG_W-1:0] ct, logic [XLEN-1:0] cd,
                              logic iss, logic ef, logic er, logic [OP_W-1:0] eop,
                              logic [TAG_W-1:0] erd, logic [XLEN-1:0] e1, logic [XLEN-1:0] e2);
    return '{fl, dv, op, rd, r1, t1, v1, r2, t2, v2, cv, ct, cd, iss, ef, er, eop, erd, e1, e2};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    flush = t.fl; disp_valid = t.dv; disp_op = t.op; disp_rd_tag = t.rd;
    disp_rs1_rdy = t.r1; disp_rs1_tag = t.t1; disp_rs1_val = t.v1;
    disp_rs2_rdy = t.r2; disp_rs2_tag = t.t2; disp_rs2_val = t.v2;
    cdb_valid = t.cv; cdb_tag = t.ct; cdb_data = t.cd; issue_int = t.iss;
  endtask

  initial begin
    pay_t p;
    // test 2: basic dispatch / issue
    tbl.push_back(mk(0,1, 3,5, 1,0,'h10, 1,0,'h20, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,1, 3,5,'h10,'h20));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    // test 3: CDB wakeup latency
    tbl.push_back(mk(0,1, 1,6, 0,7,0, 1,0,'h2, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 1,7,'hABCD, 1, 0,BYP, 1,6,'hABCD,'h2));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,!BYP, 1,6,'hABCD,'h2));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    // test 4: fill, drop while full, out-of-order issue, collapse
    tbl.push_back(mk(0,1, 2,1, 0,8,0, 1,0,'h1, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1, 4,2, 1,0,'h21, 1,0,'h22, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1, 5,3, 1,0,'h31, 1,0,'h32, 0,0,0, 0, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,1, 6,4, 1,0,'h41, 1,0,'h42, 0,0,0, 0, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,1, 7,9, 1,0,'h91, 1,0,'h92, 0,0,0, 1, 1,1, 4,2,'h21,'h22));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,1, 5,3,'h31,'h32));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,1, 6,4,'h41,'h42));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 1,8,'h88, 1, 0,BYP, 2,1,'h88,'h1));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,!BYP, 2,1,'h88,'h1));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    // CDB capture into an entry that shifts down in the same cycle
    tbl.push_back(mk(0,1, 9,10, 1,0,'h1, 1,0,'h2, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1, 10,11, 0,11,0, 1,0,'h7, 0,0,0, 0, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 1,11,'h1111, 1, 0,1, 9,10,'h1,'h2));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,1, 10,11,'h1111,'h7));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    // test 5: dispatch bypass; an already-ready operand keeps its value
    tbl.push_back(mk(0,1, 8,12, 0,9,'hDEAD, 1,9,'h3, 1,9,'h55, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,1, 8,12,'h55,'h3));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    // test 6: flush beats same-cycle issue and dispatch
    tbl.push_back(mk(0,1, 11,13, 1,0,'hA, 1,0,'hB, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,1, 12,14, 1,0,'hC, 1,0,'hD, 0,0,0, 0, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,1, 13,15, 1,0,'hE, 1,0,'hF, 0,0,0, 0, 0,1, 0,0,0,0));
    tbl.push_back(mk(1,1, 14,1, 1,0,'h1, 1,0,'h1, 0,0,0, 1, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1, 0,0, 0,0,0,0));

    // test 1: reset held while dispatching
    drive(mk(0,1, 3,5, 1,0,'h10, 1,0,'h20, 0,0,0, 1, 0,0, 0,0,0,0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_full[%0d]", k), rs_full, 0);
      chk($sformatf("rst_ready[%0d]", k), ready_int, 0);
      chk($sformatf("rst_iss[%0d]", k), {iss_op, iss_rd_tag, iss_rs1_val, iss_rs2_val}, 0);
    end
    @(posedge clk);
    #1 reset = 1;
    drive(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));

    foreach (tbl[k]) begin
      @(posedge clk);
      #1 drive(tbl[k]);
      if (tbl[k].iss && tbl[k].er && !tbl[k].fl) exp_q.push_back('{tbl[k].eop, tbl[k].erd, tbl[k].e1, tbl[k].e2});
      @(negedge clk);
      chk($sformatf("full[%0d]", k), rs_full, tbl[k].ef);
      chk($sformatf("ready[%0d]", k), ready_int, tbl[k].er);
      if (!ready_int)
        chk($sformatf("iss_zero[%0d]", k), {iss_op, iss_rd_tag, iss_rs1_val, iss_rs2_val}, 0);
      else if (issue_int && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue[%0d] unexpected issue rd_tag=%0h required=none", k, iss_rd_tag);
        end else begin
          p = exp_q.pop_front();
          chk($sformatf("issue[%0d]", k), {iss_op, iss_rd_tag, iss_rs1_val, iss_rs2_val}, {p.op, p.rd, p.v1, p.v2});
        end
      end
    end

    // asynchronous reset in the middle of a cycle discards a ready entry
    @(posedge clk);
    #1 drive(mk(0,1, 6,7, 1,0,'h77, 1,0,'h78, 0,0,0, 0, 0,0, 0,0,0,0));
    @(posedge clk);
    #1 drive(mk(0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0));
    @(negedge clk);
    chk("mid_pre_ready", ready_int, 1);
    chk("mid_pre_iss", {iss_op, iss_rd_tag, iss_rs1_val, iss_rs2_val}, {5'd6, 4'd7, 32'h77, 32'h78});
    #2 reset = 0;
    #1;
    chk("mid_rst_ready", ready_int, 0);
    chk("mid_rst_iss", {iss_op, iss_rd_tag, iss_rs1_val, iss_rs2_val}, 0);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("post_rst_ready", ready_int, 0);
    chk("post_rst_full", rs_full, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
